// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and width helper for the round-robin arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCK
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: first eligible channel at or after ptr, wrapping modulo NUM_REQ
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int SEL_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   pick,
    output logic               found
);

    localparam logic [SEL_W:0] NR = (SEL_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;
    logic [SEL_W:0]       sum;
    logic [SEL_W:0]       wrapped;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation
    always_comb begin
        dbl     = {eligible, eligible} >> ptr;
        rot     = dbl[NUM_REQ-1:0];
        found   = |rot;
        off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        sum     = {1'b0, ptr} + {1'b0, off};
        wrapped = (sum >= NR) ? sum - NR : sum;
        pick    = wrapped[SEL_W-1:0];
    end

endmodule

// File: rtl/arb_rr_grant.sv
// arb_rr_grant: round-robin arbiter with registered grant, valid/ready handshake, mask and burst lock
module arb_rr_grant
    import arb_pkg::*;
#(
    parameter int NUM_REQ   = 16,
    parameter int SEL_W     = clog2(NUM_REQ),
    parameter int FIXED_PRI = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic               lock_en,
    input  logic               gnt_last,
    output logic               gnt_vld,
    input  logic               gnt_rdy,
    output logic [SEL_W-1:0]   gnt_sel,
    output logic [NUM_REQ-1:0] gnt_onehot
);

    localparam logic [SEL_W-1:0]   LAST = SEL_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] gnt_sel_q, gnt_sel_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [NUM_REQ-1:0] eligible;
    logic [SEL_W-1:0]   sel_inc;
    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick;
    logic               found;
    logic               hs;

    // A single picker serves both the idle pick (from ptr) and the back-to-back re-pick (from sel+1)
    always_comb begin
        eligible = req & ~req_mask;
        hs       = gnt_vld_q & gnt_rdy;
        sel_inc  = (gnt_sel_q == LAST) ? '0 : gnt_sel_q + 1'b1;
        pick_ptr = (FIXED_PRI != 0) ? '0 : (state_q == IDLE) ? ptr_q : sel_inc;
    end

    arb_rr_pick #(
        .NUM_REQ(NUM_REQ),
        .SEL_W  (SEL_W)
    ) u_pick (
        .eligible(eligible),
        .ptr     (pick_ptr),
        .pick    (pick),
        .found   (found)
    );

    // Next-state: grants are sticky until handshake; a lock pins the channel until the last beat
    always_comb begin
        state_d   = state_q;
        gnt_sel_d = gnt_sel_q;
        gnt_vld_d = gnt_vld_q;
        ptr_d     = ptr_q;
        if (state_q == IDLE) begin
            if (found) begin
                gnt_sel_d = pick;
                gnt_vld_d = 1'b1;
                state_d   = GRANT;
            end
        end else if (hs) begin
            if (lock_en && !gnt_last) begin
                state_d = LOCK;
            end else begin
                ptr_d     = (FIXED_PRI != 0) ? '0 : sel_inc;
                gnt_sel_d = found ? pick : gnt_sel_q;
                gnt_vld_d = found;
                state_d   = found ? GRANT : IDLE;
            end
        end
    end

    // State and output registers; reset overrides any handshake or lock in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_sel_q <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_sel_q <= gnt_sel_d;
            gnt_vld_q <= gnt_vld_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt_vld    = gnt_vld_q;
    assign gnt_sel    = gnt_sel_q;
    assign gnt_onehot = gnt_vld_q ? (ONE << gnt_sel_q) : '0;

endmodule
